wbu: RTL and testbench

- Writeback stage between the execute unit and the architectural register file.
- Accepts one retired-instruction result per handshake from EXU.
- For loads: issues a single-beat memory read, waits for the response, then extracts and sign/zero-extends the addressed byte, halfword or word.
- Drives the register-file write port (wen/waddr/wdata) for one cycle per instruction and emits a commit pulse with the instruction PC.

---
 rtl/wbu.sv | 153 +++++++++++++++
 tb/tb_wbu.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// wbu: writeback stage between the execute unit and the register file.
// Takes one retired result per handshake. Loads issue a single-beat read
// and are then byte/halfword/word extracted. The stage produces one
// register-file write and one commit pulse per instruction.
// Optional build macro WBU_COMMIT_CNT_EN adds the 64-bit o_commit_cnt output.
`timescale 1ns/1ps
module wbu #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_exu_valid,
  output logic            o_exu_ready,
  input  logic [XLEN-1:0] i_exu_pc,
  input  logic [RA_W-1:0] i_exu_rd,
  input  logic            i_exu_rdwen,
  input  logic [XLEN-1:0] i_exu_result,
  input  logic            i_exu_is_load,
  input  logic [2:0]      i_exu_ldop,
  output logic            o_lsu_req_valid,
  input  logic            i_lsu_req_ready,
  output logic [XLEN-1:0] o_lsu_addr,
  input  logic            i_lsu_rsp_valid,
  input  logic [XLEN-1:0] i_lsu_rdata,
  output logic            o_rf_wen,
  output logic [RA_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_commit,
  output logic [XLEN-1:0] o_commit_pc
`ifdef WBU_COMMIT_CNT_EN
  ,
  output logic [63:0]     o_commit_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT, WB} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, result_reg;
  logic [RA_W-1:0] rd_reg;
  logic            rdwen_reg;
  logic [2:0]      ldop_reg;
  // Write-port image; only updated on entry to WB so it holds otherwise.
  logic [RA_W-1:0] waddr_reg;
  logic [XLEN-1:0] wdata_reg, commit_pc_reg;
  logic            wen_ok_reg;

  logic            accept;
  logic            rsp_take;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  assign accept   = i_exu_valid & o_exu_ready;
  assign rsp_take = (state_reg == LD_WAIT) & i_lsu_rsp_valid;

  assign o_lsu_addr  = {result_reg[XLEN-1:2], 2'b00};
  assign o_rf_waddr  = waddr_reg;
  assign o_rf_wdata  = wdata_reg;
  assign o_commit_pc = commit_pc_reg;

  // Lane select: byte by result[1:0], halfword by result[1] (result[0] ignored).
  assign ld_byte = i_lsu_rdata[{result_reg[1:0], 3'b000} +: 8];
  assign ld_half = i_lsu_rdata[{result_reg[1], 4'b0000} +: 16];

  // Sign/zero extension by load funct3; unknown codes fall back to a word load.
  always_comb begin
    ld_ext = i_lsu_rdata;
    case (ldop_reg)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = i_lsu_rdata;
    endcase
  end

  // Next-state and handshake/strobe outputs; ready is forced low while in reset.
  always_comb begin
    state_next      = state_reg;
    o_exu_ready     = 1'b0;
    o_lsu_req_valid = 1'b0;
    o_commit        = 1'b0;
    o_rf_wen        = 1'b0;
    case (state_reg)
      IDLE: begin
        o_exu_ready = i_rst_n;
        if (accept) state_next = i_exu_is_load ? LD_REQ : WB;
      end
      LD_REQ: begin
        o_lsu_req_valid = 1'b1;
        if (i_lsu_req_ready) state_next = LD_WAIT;
      end
      LD_WAIT: begin
        if (i_lsu_rsp_valid) state_next = WB;
      end
      WB: begin
        o_exu_ready = i_rst_n;
        o_commit    = 1'b1;
        o_rf_wen    = wen_ok_reg;
        if (accept) state_next = i_exu_is_load ? LD_REQ : WB;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus instruction capture and write-port image update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      result_reg    <= '0;
      rd_reg        <= '0;
      rdwen_reg     <= 1'b0;
      ldop_reg      <= 3'b000;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      commit_pc_reg <= '0;
      wen_ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        pc_reg     <= i_exu_pc;
        result_reg <= i_exu_result;
        rd_reg     <= i_exu_rd;
        rdwen_reg  <= i_exu_rdwen;
        ldop_reg   <= i_exu_ldop;
      end
      if (accept && !i_exu_is_load) begin
        waddr_reg     <= i_exu_rd;
        wdata_reg     <= i_exu_result;
        commit_pc_reg <= i_exu_pc;
        wen_ok_reg    <= i_exu_rdwen & (i_exu_rd != '0);
      end else if (rsp_take) begin
        waddr_reg     <= rd_reg;
        wdata_reg     <= ld_ext;
        commit_pc_reg <= pc_reg;
        wen_ok_reg    <= rdwen_reg & (rd_reg != '0);
      end
    end
  end

`ifdef WBU_COMMIT_CNT_EN
  // Free-running retire counter, wraps naturally at 2^64.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      o_commit_cnt <= 64'd0;
    else if (o_commit) o_commit_cnt <= o_commit_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed plus randomized checks of the writeback stage against a
// behavioural model of load extraction and commit sequencing.
`timescale 1ns/1ps
module tb_wbu;

  logic        clk;
  logic        rst_n;
  logic        exu_valid;
  logic        exu_ready;
  logic [31:0] exu_pc;
  logic [4:0]  exu_rd;
  logic        exu_rdwen;
  logic [31:0] exu_result;
  logic        exu_is_load;
  logic [2:0]  exu_ldop;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit;
  logic [31:0] commit_pc;
`ifdef WBU_COMMIT_CNT_EN
  logic [63:0] commit_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  logic [4:0]  last_waddr;
  logic [31:0] last_wdata;

  wbu dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_exu_valid     (exu_valid),
    .o_exu_ready     (exu_ready),
    .i_exu_pc        (exu_pc),
    .i_exu_rd        (exu_rd),
    .i_exu_rdwen     (exu_rdwen),
    .i_exu_result    (exu_result),
    .i_exu_is_load   (exu_is_load),
    .i_exu_ldop      (exu_ldop),
    .o_lsu_req_valid (lsu_req_valid),
    .i_lsu_req_ready (lsu_req_ready),
    .o_lsu_addr      (lsu_addr),
    .i_lsu_rsp_valid (lsu_rsp_valid),
    .i_lsu_rdata     (lsu_rdata),
    .o_rf_wen        (rf_wen),
    .o_rf_waddr      (rf_waddr),
    .o_rf_wdata      (rf_wdata),
    .o_commit        (commit),
    .o_commit_pc     (commit_pc)
`ifdef WBU_COMMIT_CNT_EN
    ,
    .o_commit_cnt    (commit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load result: pick the lane arithmetically, then extend.
  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] off, b, h;
    off = a % 32'd4;
    b   = (w >> (off * 32'd8)) % 32'd256;
    h   = (w >> ((off / 32'd2) * 32'd16)) % 32'd65536;
    case (op)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic check_commit(input string tag, input logic [31:0] pc, input logic [4:0] rd,
                              input logic rdwen, input logic [31:0] data);
    chk({tag, "_commit"}, commit, 1'b1);
    chk({tag, "_wen"}, rf_wen, rdwen && (rd != 5'd0));
    chk({tag, "_waddr"}, rf_waddr, rd);
    chk({tag, "_wdata"}, rf_wdata, data);
    chk({tag, "_pc"}, commit_pc, pc);
    last_waddr = rd;
    last_wdata = data;
    txn++;
    $display("txn %0d %s pc=%08h rd=%0d rdwen=%0b wdata=%08h", txn, tag, pc, rd, rdwen, data);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_commit"}, commit, 1'b0);
    chk({tag, "_wen"}, rf_wen, 1'b0);
    chk({tag, "_waddr_hold"}, rf_waddr, last_waddr);
    chk({tag, "_wdata_hold"}, rf_wdata, last_wdata);
  endtask

  task automatic drive_exu(input logic [31:0] pc, input logic [4:0] rd, input logic rdwen,
                           input logic [31:0] res, input logic ld, input logic [2:0] op);
    exu_valid = 1'b1; exu_pc = pc; exu_rd = rd; exu_rdwen = rdwen;
    exu_result = res; exu_is_load = ld; exu_ldop = op;
  endtask

  task automatic nonload(input string tag, input logic [31:0] pc, input logic [4:0] rd,
                         input logic rdwen, input logic [31:0] res);
    chk({tag, "_ready"}, exu_ready, 1'b1);
    drive_exu(pc, rd, rdwen, res, 1'b0, 3'd0);
    @(posedge clk); #1;
    exu_valid = 1'b0;
    check_commit(tag, pc, rd, rdwen, res);
  endtask

  // Load: hold = cycles req_valid stays up, wcyc = LD_WAIT cycles before rsp.
  task automatic load(input string tag, input logic [31:0] pc, input logic [4:0] rd,
                      input logic rdwen, input logic [31:0] addr, input logic [2:0] op,
                      input logic [31:0] rdata, input int hold, input int wcyc, input logic noise);
    chk({tag, "_ready"}, exu_ready, 1'b1);
    drive_exu(pc, rd, rdwen, addr, 1'b1, op);
    @(posedge clk); #1;
    exu_valid = 1'b0; exu_is_load = 1'b0;
    for (int c = 0; c < hold; c++) begin
      chk({tag, "_req_valid"}, lsu_req_valid, 1'b1);
      chk({tag, "_addr"}, lsu_addr, {addr[31:2], 2'b00});
      chk({tag, "_busy"}, {exu_ready, commit}, 2'b00);
      lsu_req_ready = (c == hold - 1);
      lsu_rsp_valid = (c != hold - 1) && noise;
      lsu_rdata     = $urandom;
      @(posedge clk); #1;
    end
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    for (int c = 0; c < wcyc; c++) begin
      chk({tag, "_wait"}, {lsu_req_valid, commit, exu_ready}, 3'b000);
      lsu_rsp_valid = (c == wcyc - 1);
      lsu_rdata     = (c == wcyc - 1) ? rdata : $urandom;
      @(posedge clk); #1;
    end
    lsu_rsp_valid = 1'b0;
    check_commit(tag, pc, rd, rdwen, exp_load(op, addr, rdata));
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    check_idle(tag);
  endtask

  initial begin
    logic [31:0] r;
    exu_valid = 0; exu_pc = 0; exu_rd = 0; exu_rdwen = 0; exu_result = 0;
    exu_is_load = 0; exu_ldop = 0; lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rdata = 0;
    last_waddr = 0; last_wdata = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", exu_ready, 1'b0);
    chk("rst_req_valid", lsu_req_valid, 1'b0);
    chk("rst_addr", lsu_addr, 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    check_idle("rst");
    rst_n = 1'b1;
    #1;
    chk("rel_ready", exu_ready, 1'b1);
    @(posedge clk); #1;

`ifdef WBU_COMMIT_CNT_EN
    for (int i = 0; i < 10; i++) nonload("cnt", 32'h100 + 32'(i * 4), 5'(i + 1), 1'b1, $urandom);
    idle_cycle("cnt_idle");
    chk("cnt_ten", commit_cnt, 64'd10);
    rst_n = 1'b0; #1;
    chk("cnt_rst", commit_cnt, 64'd0);
    last_waddr = 0; last_wdata = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    // Single non-load, then the idle cycle must hold the write-port image.
    nonload("nl", 32'h8000_0000, 5'd5, 1'b1, 32'h1234_5678);
    idle_cycle("nl_idle");

    // Four back-to-back non-loads: one commit per cycle, ready held high.
    for (int i = 1; i <= 4; i++) begin
      r = $urandom;
      drive_exu(32'h8000_0100 + 32'(i * 4), 5'(i), 1'b1, r, 1'b0, 3'd0);
      @(posedge clk); #1;
      chk("b2b_ready", exu_ready, 1'b1);
      check_commit("b2b", 32'h8000_0100 + 32'(i * 4), 5'(i), 1'b1, r);
    end
    exu_valid = 1'b0;
    nonload("rd0", 32'h8000_0200, 5'd0, 1'b1, 32'hDEAD_BEEF);
    nonload("nowen", 32'h8000_0204, 5'd7, 1'b0, 32'hCAFE_F00D);
    idle_cycle("b2b_idle");

    // Directed loads.
    load("lb", 32'h8000_0300, 5'd9, 1'b1, 32'h8000_0003, 3'd0, 32'h80FF_0011, 3, 2, 1'b1);
    load("lhu", 32'h8000_0304, 5'd10, 1'b1, 32'h8000_0002, 3'd5, 32'h8001_7FFF, 1, 1, 1'b0);
    load("lh", 32'h8000_0308, 5'd11, 1'b1, 32'h8000_0002, 3'd1, 32'h8001_7FFF, 2, 1, 1'b0);
    load("lw", 32'h8000_030C, 5'd12, 1'b1, 32'h8000_0002, 3'd2, 32'h8001_7FFF, 1, 3, 1'b0);
    load("lbu", 32'h8000_0310, 5'd13, 1'b1, 32'h8000_0001, 3'd4, 32'h1234_F0AB, 1, 1, 1'b0);
    idle_cycle("ld_idle");

    // Reset during LD_REQ drops the request at once.
    drive_exu(32'h8000_0400, 5'd3, 1'b1, 32'h0000_1000, 1'b1, 3'd2);
    @(posedge clk); #1;
    exu_valid = 1'b0;
    chk("rq_req_valid", lsu_req_valid, 1'b1);
    rst_n = 1'b0; #1;
    chk("rq_rst_req_valid", lsu_req_valid, 1'b0);
    chk("rq_rst_ready", exu_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_waddr = 0; last_wdata = 0;
    @(posedge clk); #1;

    // Reset during LD_WAIT; a late response must be ignored.
    drive_exu(32'h8000_0500, 5'd4, 1'b1, 32'h0000_2000, 1'b1, 3'd2);
    @(posedge clk); #1;
    exu_valid = 1'b0;
    lsu_req_ready = 1'b1;
    @(posedge clk); #1;
    lsu_req_ready = 1'b0;
    chk("rw_in_wait", {lsu_req_valid, exu_ready}, 2'b00);
    rst_n = 1'b0; #1;
    chk("rw_rst_ready", exu_ready, 1'b0);
    check_idle("rw_rst");
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("rw_rel_ready", exu_ready, 1'b1);
    lsu_rsp_valid = 1'b1; lsu_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    lsu_rsp_valid = 1'b0;
    chk("rw_late_ready", exu_ready, 1'b1);
    chk("rw_late_req", lsu_req_valid, 1'b0);
    check_idle("rw_late");

    // Randomized mix of loads and non-loads.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] pc, res;
      logic [4:0]  rd;
      logic        rdwen;
      pc    = $urandom & 32'hFFFF_FFFC;
      res   = $urandom;
      rd    = 5'($urandom_range(0, 31));
      rdwen = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1)
        load("rnd_ld", pc, rd, rdwen, res, 3'($urandom_range(0, 7)), $urandom,
             $urandom_range(1, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      else
        nonload("rnd_nl", pc, rd, rdwen, res);
      if ($urandom_range(0, 3) == 0) idle_cycle("rnd_idle");
    end
    idle_cycle("end_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
